// File: rtl/sh_timer_unit_if.sv
// DBUS slave port of the SH multi-channel timer.
// Carries the address, data and strobes in, and the read data and status out.
interface sh_timer_unit_if;
    logic [31:0] IBUS_A;
    logic [31:0] IBUS_DI;
    logic [31:0] IBUS_DO;
    logic [3:0]  IBUS_BA;
    logic        IBUS_WE;
    logic        IBUS_REQ;
    logic        IBUS_BUSY;
    logic        IBUS_ACT;

    modport master (output IBUS_A, IBUS_DI, IBUS_BA, IBUS_WE, IBUS_REQ,
                    input  IBUS_DO, IBUS_BUSY, IBUS_ACT);
    modport slave  (input  IBUS_A, IBUS_DI, IBUS_BA, IBUS_WE, IBUS_REQ,
                    output IBUS_DO, IBUS_BUSY, IBUS_ACT);
endinterface

// File: rtl/sh_timer_unit.sv
// Multi-channel compare/overflow timer with a shared prescaler and an external clock input.
// Each channel has compare-match auto-clear, one-shot stop, a TO pin and a level IRQ.
module sh_timer_unit #(
    parameter int          CHANNELS  = 4,
    parameter int          WIDTH     = 16,
    parameter logic [31:0] BASE_ADDR = 32'hFFFFFC00
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic                CE_R,
    input  logic                CE_F,
    sh_timer_unit_if.slave      bus,
    input  logic                TCLK,
    output logic [CHANNELS-1:0] TO,
    output logic [CHANNELS-1:0] IRQ
);
    typedef logic [WIDTH-1:0] cnt_t;

    logic [7:0]          pre_q, pre_d;
    logic [2:0]          tclk_q, tclk_d;
    logic [CHANNELS-1:0] tstr_q, tstr_d, to_q, to_d;
    logic [CHANNELS-1:0] cmf_q, cmf_d, ovf_q, ovf_d;
    logic [CHANNELS-1:0] cmie_q, cmie_d, ovie_q, ovie_d;
    logic [5:0]          tcr_q [CHANNELS];
    logic [5:0]          tcr_d [CHANNELS];
    cnt_t                tcnt_q [CHANNELS];
    cnt_t                tcnt_d [CHANNELS];
    cnt_t                tcmp_q [CHANNELS];
    cnt_t                tcmp_d [CHANNELS];

    logic        hit, is_tstr, is_ch, act, wr_en;
    logic [2:0]  ch_sel;
    logic [1:0]  reg_sel;
    logic [31:0] rdata, lane_m, wdata;
    logic [3:0]  pre_tick;
    logic        ext_rise, ext_fall;
    logic [1:0]  flag_clr;

    logic [CHANNELS-1:0] wr_ch, tick, wrap, match, ovf_set;
    cnt_t                nxt [CHANNELS];
    logic                unused_ok;

    function automatic logic [31:0] lane_mask(input logic [3:0] ba);
        return {{8{ba[3]}}, {8{ba[2]}}, {8{ba[1]}}, {8{ba[0]}}};
    endfunction

    function automatic logic sel_tick(input logic [2:0] cks, input logic [3:0] pt,
                                      input logic rise, input logic fall);
        case (cks)
            3'd0:    return pt[0];
            3'd1:    return pt[1];
            3'd2:    return pt[2];
            3'd3:    return pt[3];
            3'd4:    return rise;
            3'd5:    return fall;
            default: return 1'b0;
        endcase
    endfunction

    // Address decode: channel n at 0x10*n, TSTR at 0x80; low two address bits are lane-selected.
    assign hit     = bus.IBUS_REQ && (bus.IBUS_A[31:8] == BASE_ADDR[31:8]);
    assign ch_sel  = bus.IBUS_A[6:4];
    assign reg_sel = bus.IBUS_A[3:2];
    assign is_tstr = (bus.IBUS_A[7:2] == 6'h20);
    assign is_ch   = !bus.IBUS_A[7] && (int'(ch_sel) < CHANNELS);
    assign act     = hit && (is_tstr || is_ch);
    assign wr_en   = act && bus.IBUS_WE && CE_R;

    assign lane_m   = lane_mask(bus.IBUS_BA);
    assign wdata    = (rdata & ~lane_m) | (bus.IBUS_DI & lane_m);
    assign flag_clr = bus.IBUS_DI[1:0] & {2{bus.IBUS_BA[0]}};

    assign bus.IBUS_DO   = rdata;
    assign bus.IBUS_ACT  = act;
    assign bus.IBUS_BUSY = 1'b0;

    always_comb begin
        rdata = '0;
        if (act) begin
            if (is_tstr) rdata = 32'(tstr_q);
            for (int i = 0; i < CHANNELS; i++) begin
                if (is_ch && ch_sel == 3'(i)) begin
                    case (reg_sel)
                        2'd0:    rdata = 32'(tcr_q[i]);
                        2'd1:    rdata = 32'(tcnt_q[i]);
                        2'd2:    rdata = 32'(tcmp_q[i]);
                        default: rdata = {22'd0, ovie_q[i], cmie_q[i], 6'd0, ovf_q[i], cmf_q[i]};
                    endcase
                end
            end
        end
    end

    assign pre_tick = {pre_q == 8'hFF, pre_q[5:0] == 6'h3F, pre_q[3:0] == 4'hF, pre_q[1:0] == 2'h3};
    // tclk_q[1] is the synchronised level, tclk_q[2] its previous value.
    assign ext_rise = tclk_q[1] & ~tclk_q[2];
    assign ext_fall = ~tclk_q[1] & tclk_q[2];

    always_comb begin
        pre_d   = pre_q + 8'd1;
        tclk_d  = {tclk_q[1], tclk_q[0], TCLK};
        tstr_d  = tstr_q;
        to_d    = to_q;
        cmf_d   = cmf_q;
        ovf_d   = ovf_q;
        cmie_d  = cmie_q;
        ovie_d  = ovie_q;
        wr_ch   = '0;
        tick    = '0;
        wrap    = '0;
        match   = '0;
        ovf_set = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            tcr_d[i]  = tcr_q[i];
            tcnt_d[i] = tcnt_q[i];
            tcmp_d[i] = tcmp_q[i];
            wr_ch[i]  = wr_en && is_ch && (ch_sel == 3'(i));
            tick[i]   = tstr_q[i] && sel_tick(tcr_q[i][2:0], pre_tick, ext_rise, ext_fall);

            nxt[i] = tcnt_q[i] + cnt_t'(1);
            if (tcr_q[i][3] && tcnt_q[i] == tcmp_q[i]) begin
                nxt[i] = '0;
            end else if (tcnt_q[i] == '1) begin
                nxt[i]  = '0;
                wrap[i] = 1'b1;
            end

            // A CPU write to TCNT pre-empts the tick entirely, suppressing match and overflow.
            if (wr_ch[i] && reg_sel == 2'd1) begin
                tcnt_d[i] = wdata[WIDTH-1:0];
            end else if (tick[i]) begin
                tcnt_d[i]  = nxt[i];
                match[i]   = (nxt[i] == tcmp_q[i]);
                ovf_set[i] = wrap[i];
            end

            if (wr_ch[i] && reg_sel == 2'd0) begin
                tcr_d[i] = wdata[5:0];
                to_d[i]  = 1'b0;
            end else if (match[i]) begin
                to_d[i] = tcr_q[i][4] | ~to_q[i];
            end

            if (wr_ch[i] && reg_sel == 2'd2) tcmp_d[i] = wdata[WIDTH-1:0];

            if (wr_ch[i] && reg_sel == 2'd3) begin
                if (flag_clr[0]) cmf_d[i] = 1'b0;
                if (flag_clr[1]) ovf_d[i] = 1'b0;
                cmie_d[i] = wdata[8];
                ovie_d[i] = wdata[9];
            end
            if (match[i])   cmf_d[i] = 1'b1;
            if (ovf_set[i]) ovf_d[i] = 1'b1;

            if (match[i] && tcr_q[i][5]) tstr_d[i] = 1'b0;
        end
        if (wr_en && is_tstr) tstr_d = wdata[CHANNELS-1:0];
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            pre_q  <= '0;
            tclk_q <= '0;
            tstr_q <= '0;
            to_q   <= '0;
            cmf_q  <= '0;
            ovf_q  <= '0;
            cmie_q <= '0;
            ovie_q <= '0;
            for (int i = 0; i < CHANNELS; i++) begin
                tcr_q[i]  <= '0;
                tcnt_q[i] <= '0;
                tcmp_q[i] <= '1;
            end
        end else if (CE_R) begin
            pre_q  <= pre_d;
            tclk_q <= tclk_d;
            tstr_q <= tstr_d;
            to_q   <= to_d;
            cmf_q  <= cmf_d;
            ovf_q  <= ovf_d;
            cmie_q <= cmie_d;
            ovie_q <= ovie_d;
            tcr_q  <= tcr_d;
            tcnt_q <= tcnt_d;
            tcmp_q <= tcmp_d;
        end
    end

    assign TO  = to_q;
    assign IRQ = (cmf_q & cmie_q) | (ovf_q & ovie_q);

    assign unused_ok = ^{CE_F, bus.IBUS_A[1:0], wdata};
endmodule

// File: doc/sh_timer_unit.md
# sh_timer_unit

Parametrised multi-channel compare/overflow timer for the SH on-chip peripheral set, sitting on the internal DBUS beside the FRT, WDT and SCI. It is the generalised successor of the single-channel free-running timer. It provides:
- CHANNELS independent WIDTH-bit counters, each with a selectable internal prescale or external clock edge.
- Compare-match with optional auto-clear and one-shot stop, plus a per-channel compare output pin.
- Per-channel level interrupt requests.

The block contains its own prescaler, so it depends only on the CPU clock enables.

## Interface
Parameters:
- CHANNELS, 4: number of timer channels, 1..8.
- WIDTH, 16: counter/compare width, 8..32. Register bits above WIDTH read 0 and ignore writes.
- BASE_ADDR, 32'hFFFFFC00: base of the register window. Must be 256-byte aligned.

Ports:
- CLK in 1: system clock.
- RST in 1: asynchronous, active-high reset.
- CE_R in 1: rising-phase clock enable. All state updates happen on CLK edges with CE_R=1.
- CE_F in 1: falling-phase enable. Unused; present for port uniformity.
- IBUS_A in 32: access address.
- IBUS_DI in 32: write data.
- IBUS_DO out 32: read data.
- IBUS_BA in 4: byte enables; bit3 = byte lane [31:24].
- IBUS_WE in 1: write strobe.
- IBUS_REQ in 1: access request.
- IBUS_BUSY out 1: wait request. Constant 0, since all accesses are zero-wait.
- IBUS_ACT out 1: combinational; 1 when IBUS_REQ=1 and IBUS_A[31:8]==BASE_ADDR[31:8] and the offset decodes to an implemented register.
- TCLK in 1: external count clock, asynchronous.
- TO out CHANNELS: compare outputs.
- IRQ out CHANNELS: per-channel interrupt request, level.

## Operation
Register map (offsets from BASE_ADDR). Channel n occupies 0x10*n; all registers are 32-bit.
- +0x0 TCR:
  - [2:0] CKS: 0=CE/4, 1=CE/16, 2=CE/64, 3=CE/256, 4=TCLK rising edge, 5=TCLK falling edge, 6/7=no count.
  - [3] CCLR: clear on compare match.
  - [4] OMODE: 0=toggle TO on match, 1=set TO on match.
  - [5] ONESHOT.
  - A write to TCR forces TO[n]=0.
- +0x4 TCNT: counter, read/write.
- +0x8 TCMP: compare value.
- +0xC TSR:
  - [0] CMF, [1] OVF: write 1 to clear.
  - [8] CMIE, [9] OVIE: read/write.
- 0x80 TSTR: bit n = channel n run. Read/write.
- Unimplemented offsets: IBUS_ACT=0.

Bus rules:
- A write occurs when IBUS_REQ & IBUS_WE & IBUS_ACT on a CE_R cycle.
- Only lanes with IBUS_BA set are updated.
- IBUS_DO is combinational from the addressed register; it is 0 when IBUS_ACT=0.

Prescaler:
- 8-bit free-running counter P, incremented every CE_R.
- Tick pulses (one CE_R cycle each): /4 when P[1:0]==3, /16 when P[3:0]==F, /64 when P[5:0]==3F, /256 when P==FF.

External clock:
- TCLK passes through a 2-flop synchroniser (CE_R-gated), then a 1-flop edge detector.
- The resulting tick is one CE_R cycle wide.

Counting, per channel, on a tick with TSTR[n]=1:
- If CCLR=1 and TCNT==TCMP: TCNT becomes 0.
- Else if TCNT==all-ones: TCNT becomes 0 and OVF is set.
- Else TCNT becomes TCNT+1.
- Compare match is asserted when the next TCNT value equals TCMP. This covers a clear-to-0 match when TCMP=0.
- On a match:
  - CMF is set.
  - TO[n] toggles or is set, per OMODE.
  - If ONESHOT=1, TSTR[n] is cleared in the same cycle.
- Resulting period with CCLR=1: TCMP+1 ticks.

Priorities:
- CPU write to TCNT in the same cycle as a tick: the write wins; no match and no overflow that cycle.
- Flag set and write-1-clear in the same cycle: set wins.
- CPU write to TSTR and a one-shot stop in the same cycle: the CPU write wins.

Interrupts:
- IRQ[n] = (CMF&CMIE) | (OVF&OVIE), combinational from registered state.

## Timing
- Reset values:
  - All registers, P and the synchronisers are 0; TCMP = all-ones.
  - TO=0, IRQ=0, IBUS_DO=0, IBUS_ACT=0, IBUS_BUSY=0.
- Reset asserted mid-count: all state clears immediately (asynchronous); counting resumes only after software sets TSTR.
- Register writes are visible on IBUS_DO the cycle after the write edge.
- Tick to TCNT update: 1 CE_R edge. CMF, TO and IRQ change on that same edge.
- TCLK edge to tick: 3 CE_R edges. Minimum TCLK high and low time is 2 CE_R periods each; shorter pulses may be lost.
- CE_R=0 freezes all state, including P.

## Test plan
1. Write TCMP0=4, TCR0=0x08 (CE/4, CCLR), TSR0=0x100, TSTR=1 -> TCNT0 sequence is 0,1,2,3,4,0 with one tick every 4 CE_R cycles; CMF and IRQ[0] rise on the edge loading 4; TO[0] toggles every 20 CE_R cycles.
2. WIDTH=16, TCNT1=0xFFFE, CKS=0, OVIE=1, start -> after 2 ticks TCNT1=0 and OVF=1; IRQ[1]=1; writing TSR1=0x202 clears OVF and IRQ[1] drops the next cycle.
3. ONESHOT=1, OMODE=1, TCMP=2, CCLR=1 -> TO goes to 1 at the match, TSTR bit clears, and TCNT stays at 2.
4. CKS=5, toggle TCLK 6 times with 4-cycle high/low phases -> TCNT=3 counted on falling edges only, each 3 CE_R edges after the synchronised edge.
5. Write TCNT=0x10 in the cycle a tick occurs at TCNT==TCMP-1 -> TCNT=0x10 and CMF stays 0; a write-1 clear of CMF coinciding with a new match leaves CMF=1.
6. Assert RST while running with CMF=1 -> all outputs 0 immediately; after release, TCMP reads 0xFFFF (WIDTH=16) and a byte-lane write with IBUS_BA=4'b0001 to TCMP yields 0xFF55 when the data is 0x55.
